// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 encodings,
// the FSM state type and the access legality check.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        FIN      = 2'd3
    } lsu_state_t;

    // An access faults when it is both load and store, uses an encoding that
    // is not a load/store of its kind, or is not naturally aligned.
    function automatic logic access_fault(
        input logic       rd,
        input logic       wr,
        input logic [2:0] f3,
        input logic [1:0] lo
    );
        logic bad;
        bad = rd && wr;
        if (rd && !(f3 inside {LB, LH, LW, LBU, LHU})) bad = 1'b1;
        if (wr && !(f3 inside {SB, SH, SW}))           bad = 1'b1;
        if ((rd || wr) && (f3 == LH || f3 == LHU) && lo[0]) bad = 1'b1;
        if ((rd || wr) && (f3 == LW) && (lo != 2'b00))      bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/store_align.sv
// Combinational store lane steering: byte enables and lane-replicated data
// for SB/SH/SW at a given byte offset within the word.
module store_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        mem_be    = 4'b0000;
        mem_wdata = '0;
        case (funct3)
            SB: begin
                mem_be    = 4'b0001 << addr_lo;
                mem_wdata = {4{wdata[7:0]}};
            end
            SH: begin
                mem_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{wdata[15:0]}};
            end
            SW: begin
                mem_be    = 4'b1111;
                mem_wdata = wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one access per handshake, word-aligned memory
// request with byte enables, right-aligned zero-filled load data.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  fault
);

    lsu_state_t            state_q, state_d;
    logic                  op_read_q, op_read_d;
    logic                  op_write_q, op_write_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
    logic                  fault_q, fault_d;

    logic                  in_req;
    logic [3:0]            st_be;
    logic [DATA_WIDTH-1:0] st_wdata;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [DATA_WIDTH-1:0] aligned;

    store_align u_store_align (
        .funct3    (funct3_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .mem_be    (st_be),
        .mem_wdata (st_wdata)
    );

    // Request outputs come straight from the latched access, so they cannot
    // move while REQ waits for mem_req_ready; they read as zero elsewhere.
    assign in_req        = (state_q == REQ);
    assign mem_req_valid = in_req;
    assign mem_addr      = in_req ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
    assign mem_we        = in_req && op_write_q;
    assign mem_be        = !in_req ? 4'b0000 : (op_write_q ? st_be : 4'b1111);
    assign mem_wdata     = (in_req && op_write_q) ? st_wdata : '0;

    assign req_ready = (state_q == IDLE);
    assign done      = (state_q == FIN);
    assign load_data = load_data_q;
    assign fault     = fault_q;

    always_comb begin
        rd_byte = mem_rdata[7:0];
        rd_half = mem_rdata[15:0];
        case (addr_q[1:0])
            2'd1: begin
                rd_byte = mem_rdata[15:8];
                rd_half = mem_rdata[23:8];
            end
            2'd2: begin
                rd_byte = mem_rdata[23:16];
                rd_half = mem_rdata[31:16];
            end
            2'd3: begin
                rd_byte = mem_rdata[31:24];
                rd_half = {8'h00, mem_rdata[31:24]};
            end
            default: ;
        endcase
        case (funct3_q)
            LB, LBU: aligned = {24'h0, rd_byte};
            LH, LHU: aligned = {16'h0, rd_half};
            default: aligned = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_read_d   = op_read_q;
        op_write_d  = op_write_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        load_data_d = load_data_q;
        fault_d     = fault_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_read_d   = req_read;
                    op_write_d  = req_write;
                    funct3_d    = funct3;
                    addr_d      = addr;
                    wdata_d     = wdata;
                    load_data_d = '0;
                    fault_d     = access_fault(req_read, req_write, funct3, addr[1:0]);
                    if (fault_d || (!req_read && !req_write)) state_d = FIN;
                    else                                      state_d = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) state_d = op_write_q ? FIN : WAIT_RSP;
            end
            WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    load_data_d = aligned;
                    state_d     = FIN;
                end
            end
            FIN: begin
                fault_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the access latches are small, so every flop is reset to keep
    // outputs and X-propagation deterministic after rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_read_q   <= 1'b0;
            op_write_q  <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= '0;
            load_data_q <= '0;
            fault_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so all state advances together on the edge.
            state_q     <= state_d;
            op_read_q   <= op_read_d;
            op_write_q  <= op_write_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
            fault_q     <= fault_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// accesses compared against an arithmetic reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_read, req_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        req_ready;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, load_data;
    logic [3:0]  mem_be;
    logic        mem_rsp_valid, done, fault;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_read      (req_read),
        .req_write     (req_write),
        .funct3        (funct3),
        .addr          (addr),
        .wdata         (wdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .done          (done),
        .load_data     (load_data),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: legality from the RV32I encoding tables and natural alignment.
    function automatic bit model_fault(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
        bit is_half, is_word;
        is_half = (f3 == 3'd1) || (f3 == 3'd5);
        is_word = (f3 == 3'd2);
        if (rd && wr) return 1;
        if (rd && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) return 1;
        if (wr && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)) return 1;
        if ((rd || wr) && is_half && (a % 2 != 0)) return 1;
        if ((rd || wr) && is_word && (a % 4 != 0)) return 1;
        return 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input int o);
        if (f3 == 3'd0) return 4'(1 << o);
        if (f3 == 3'd1) return (o >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3 == 3'd0) return (wd & 32'hFF) * 32'h01010101;
        if (f3 == 3'd1) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input int o, input logic [31:0] word);
        logic [31:0] s;
        s = word >> (8 * o);
        if (f3 == 3'd0 || f3 == 3'd4) return s & 32'hFF;
        if (f3 == 3'd1 || f3 == 3'd5) return s & 32'hFFFF;
        return word;
    endfunction

    // Runs one access from IDLE at a negedge; returns at the negedge where the
    // unit is idle again. Inputs are scrambled after acceptance to prove latching.
    task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] word, input int stall,
                              input int rsp_dly, input string tag);
        bit          f;
        int          o;
        o = int'(a[1:0]);
        f = model_fault(rd, wr, f3, a);
        check({tag, ".ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_read = rd; req_write = wr;
        funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_read = ~rd; req_write = ~wr;
        funct3 = ~f3; addr = ~a; wdata = ~wd;
        if (f || (!rd && !wr)) begin
            check({tag, ".done"}, 32'(done), 32'd1);
            check({tag, ".fault"}, 32'(fault), 32'(f));
            check({tag, ".ld_zero"}, load_data, 32'd0);
            check({tag, ".no_mem"}, 32'(mem_req_valid), 32'd0);
        end else begin
            for (int i = 0; i <= stall; i++) begin
                check({tag, ".mreq"}, 32'(mem_req_valid), 32'd1);
                check({tag, ".maddr"}, mem_addr, a & 32'hFFFF_FFFC);
                check({tag, ".mwe"}, 32'(mem_we), 32'(wr));
                check({tag, ".mbe"}, 32'(mem_be), wr ? 32'(model_be(f3, o)) : 32'hF);
                if (wr) check({tag, ".mwdata"}, mem_wdata, model_wdata(f3, wd));
                check({tag, ".busy"}, 32'(req_ready), 32'd0);
                check({tag, ".no_done"}, 32'(done), 32'd0);
                mem_req_ready = (i == stall);
                mem_rsp_valid = (i < stall);
                mem_rdata     = $urandom;
                @(negedge clk);
            end
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            if (!wr) begin
                for (int i = 0; i <= rsp_dly; i++) begin
                    check({tag, ".wait_nomreq"}, 32'(mem_req_valid), 32'd0);
                    check({tag, ".wait_nodone"}, 32'(done), 32'd0);
                    mem_rsp_valid = (i == rsp_dly);
                    mem_rdata     = (i == rsp_dly) ? word : $urandom;
                    @(negedge clk);
                end
                mem_rsp_valid = 1'b0;
            end
            check({tag, ".done"}, 32'(done), 32'd1);
            check({tag, ".fault"}, 32'(fault), 32'd0);
            check({tag, ".ld"}, load_data, wr ? 32'd0 : model_load(f3, o, word));
        end
        @(negedge clk);
        check({tag, ".done_1cyc"}, 32'(done), 32'd0);
        check({tag, ".ready_again"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        bit          rd, wr;
        logic [2:0]  f3;
        logic [31:0] a;
        int          kind;

        rst = 1'b1; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        funct3 = 3'd0; addr = '0; wdata = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst.req_ready", 32'(req_ready), 32'd1);
        check("rst.mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst.mem_addr", mem_addr, 32'd0);
        check("rst.mem_we", 32'(mem_we), 32'd0);
        check("rst.mem_be", 32'(mem_be), 32'd0);
        check("rst.mem_wdata", mem_wdata, 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.load_data", load_data, 32'd0);
        check("rst.fault", 32'(fault), 32'd0);

        run_access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, "sw");
        run_access(0, 1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 0, "sb");
        run_access(0, 1, 3'b001, 32'h102, 32'h1234BEEF, 32'h0, 1, 0, "sh_hi");
        run_access(1, 0, 3'b000, 32'h202, 32'h0, 32'h12F45678, 0, 0, "lb");
        run_access(1, 0, 3'b101, 32'h202, 32'h0, 32'h8001ABCD, 0, 1, "lhu");
        run_access(1, 0, 3'b010, 32'h301, 32'h0, 32'h0, 0, 0, "lw_mis");
        run_access(1, 0, 3'b001, 32'h203, 32'h0, 32'h0, 0, 0, "lh_mis");
        run_access(1, 1, 3'b010, 32'h300, 32'h0, 32'h0, 0, 0, "rd_wr");
        run_access(1, 0, 3'b011, 32'h300, 32'h0, 32'h0, 0, 0, "ld_ill");
        run_access(0, 1, 3'b100, 32'h300, 32'h0, 32'h0, 0, 0, "st_ill");
        run_access(0, 0, 3'b000, 32'h300, 32'h0, 32'h0, 0, 0, "noop");
        run_access(1, 0, 3'b010, 32'h400, 32'h0, 32'hCAFEF00D, 3, 0, "lw_stall");

        // Reset while waiting for a load response; the late response must be ignored.
        req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0;
        funct3 = 3'b010; addr = 32'h500;
        @(negedge clk);
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstw.req_ready", 32'(req_ready), 32'd1);
        check("rstw.mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("rstw.done", 32'(done), 32'd0);
        check("rstw.fault", 32'(fault), 32'd0);
        mem_rsp_valid = 1'b1; mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check("late.done", 32'(done), 32'd0);
        check("late.req_ready", 32'(req_ready), 32'd1);
        check("late.load_data", load_data, 32'd0);

        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 9);
            rd = (kind == 1) || (kind >= 2 && kind <= 5);
            wr = (kind == 1) || (kind >= 6);
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            if (kind == 0) begin
                f3 = 3'd0;
                a[1:0] = 2'b00;
            end
            run_access(rd, wr, f3, a, $urandom, $urandom,
                       $urandom_range(0, 2), $urandom_range(0, 2), $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
